// File: rtl/tl_l1_req_arbiter.sv
// tl_l1_req_arbiter
// Shares one tl_l1_adapter TileLink master among NUM_REQ local requesters.
// Round-robin accept of one request at a time, launch on the adapter's
// start/done handshake, and route completion/read data back to the owner.
// A watchdog flags (sticky) an adapter transaction that runs past WD_CYCLES.

`ifndef TL_ADDR_BITS
`define TL_ADDR_BITS 32
`endif
`ifndef TL_SIZE_BITS
`define TL_SIZE_BITS 3
`endif
`ifndef TL_DATA_BYTES
`define TL_DATA_BYTES 4
`endif
`ifndef TL_SOURCE_BITS
`define TL_SOURCE_BITS 4
`endif

module tl_l1_req_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WD_CYCLES = 1023
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    // requester side
    input  logic [NUM_REQ-1:0]                         req_valid,
    output logic [NUM_REQ-1:0]                         req_ready,
    input  logic [2*NUM_REQ-1:0]                       req_type,
    input  logic [NUM_REQ*`TL_ADDR_BITS-1:0]           req_address,
    input  logic [NUM_REQ*`TL_SIZE_BITS-1:0]           req_size,
    input  logic [NUM_REQ*`TL_DATA_BYTES*8-1:0]        req_wdata,
    input  logic [NUM_REQ*`TL_DATA_BYTES-1:0]          req_wmask,
    output logic [NUM_REQ-1:0]                         resp_valid,
    output logic                                       resp_err,
    output logic [`TL_DATA_BYTES*8-1:0]                resp_rdata,
    output logic                                       wd_timeout,
    // adapter side
    output logic                                       ad_start,
    output logic [1:0]                                 ad_type,
    output logic [`TL_ADDR_BITS-1:0]                   ad_address,
    output logic [`TL_SIZE_BITS-1:0]                   ad_size,
    output logic [`TL_SOURCE_BITS-1:0]                 ad_source,
    output logic [`TL_DATA_BYTES*8-1:0]                ad_wdata,
    output logic [`TL_DATA_BYTES-1:0]                  ad_wmask,
    input  logic                                       ad_done,
    input  logic [`TL_DATA_BYTES*8-1:0]                ad_rdata
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned AW     = `TL_ADDR_BITS;
    localparam int unsigned SW     = `TL_SIZE_BITS;
    localparam int unsigned DW     = `TL_DATA_BYTES * 8;
    localparam int unsigned MW     = `TL_DATA_BYTES;
    localparam int unsigned SRCW   = `TL_SOURCE_BITS;
    localparam int unsigned CNT_W  = $clog2(WD_CYCLES + 1);

    localparam logic [CNT_W-1:0] WD_LIM   = CNT_W'(WD_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [1:0]       TYPE_GET = 2'd0;
    localparam logic [1:0]       TYPE_ILL = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e               state_q;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [IDX_W-1:0]     owner_q;
    logic                 ad_start_q;
    logic [1:0]           ad_type_q;
    logic [AW-1:0]        ad_address_q;
    logic [SW-1:0]        ad_size_q;
    logic [SRCW-1:0]      ad_source_q;
    logic [DW-1:0]        ad_wdata_q;
    logic [MW-1:0]        ad_wmask_q;
    logic [NUM_REQ-1:0]   resp_valid_q;
    logic                 resp_err_q;
    logic [DW-1:0]        resp_rdata_q;
    logic                 wd_timeout_q;
    logic [CNT_W-1:0]     wd_cnt_q;

    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic                 accept;
    logic [NUM_REQ-1:0]   owner_oh;
    logic [IDX_W-1:0]     rr_ptr_next;

    // Round-robin search: first pending requester at or after rr_ptr, with wrap.
    always_comb begin
        int unsigned      cand;
        logic [IDX_W-1:0] cand_idx;
        cand      = 0;
        cand_idx  = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand     = (32'(rr_ptr_q) + i) % NUM_REQ;
            cand_idx = cand[IDX_W-1:0];
            if (!win_found && req_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Accept strobe is combinational so the requester sees it in the accept cycle.
    always_comb begin
        accept    = (state_q == StIdle) && win_found;
        req_ready = '0;
        if (accept) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    // One-hot of the current owner and the pointer value after it completes.
    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
        rr_ptr_next       = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
    end

    // Main FSM with all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            ad_start_q   <= 1'b0;
            ad_type_q    <= '0;
            ad_address_q <= '0;
            ad_size_q    <= '0;
            ad_source_q  <= '0;
            ad_wdata_q   <= '0;
            ad_wmask_q   <= '0;
            resp_valid_q <= '0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            wd_timeout_q <= 1'b0;
            wd_cnt_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        // Fields go straight into the adapter parameter regs and stay
                        // there until the next acceptance.
                        owner_q      <= win_idx;
                        ad_type_q    <= req_type[win_idx*2 +: 2];
                        ad_address_q <= req_address[win_idx*AW +: AW];
                        ad_size_q    <= req_size[win_idx*SW +: SW];
                        ad_wdata_q   <= req_wdata[win_idx*DW +: DW];
                        ad_wmask_q   <= req_wmask[win_idx*MW +: MW];
                        ad_source_q  <= SRCW'(win_idx);
                        state_q      <= StGrant;
                    end
                end
                StGrant: begin
                    if (ad_type_q == TYPE_ILL) begin
                        // Illegal type completes with an error, adapter never started.
                        // resp_rdata keeps its previous value.
                        resp_valid_q <= owner_oh;
                        resp_err_q   <= 1'b1;
                        state_q      <= StResp;
                    end else begin
                        ad_start_q   <= 1'b1;
                        state_q      <= StIssue;
                    end
                end
                StIssue: begin
                    ad_start_q <= 1'b0;
                    wd_cnt_q   <= '0;
                    state_q    <= StWait;
                end
                StWait: begin
                    if (ad_done) begin
                        resp_valid_q <= owner_oh;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= (ad_type_q == TYPE_GET) ? ad_rdata : '0;
                        state_q      <= StResp;
                    end else if (wd_cnt_q != WD_LIM) begin
                        // Saturating count; the adapter still owns the bus after timeout.
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                        if (wd_cnt_q == WD_LIM - 1'b1) begin
                            wd_timeout_q <= 1'b1;
                        end
                    end
                end
                StResp: begin
                    resp_valid_q <= '0;
                    resp_err_q   <= 1'b0;
                    rr_ptr_q     <= rr_ptr_next;
                    state_q      <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ad_start   = ad_start_q;
    assign ad_type    = ad_type_q;
    assign ad_address = ad_address_q;
    assign ad_size    = ad_size_q;
    assign ad_source  = ad_source_q;
    assign ad_wdata   = ad_wdata_q;
    assign ad_wmask   = ad_wmask_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign wd_timeout = wd_timeout_q;

endmodule

// File: tb/tb_tl_l1_req_arbiter.sv
// Directed self-checking bench for tl_l1_req_arbiter (NUM_REQ=4, WD_CYCLES=8).
// Inputs change on the falling edge; outputs are sampled on the falling edge.

`ifndef TL_ADDR_BITS
`define TL_ADDR_BITS 32
`endif
`ifndef TL_SIZE_BITS
`define TL_SIZE_BITS 3
`endif
`ifndef TL_DATA_BYTES
`define TL_DATA_BYTES 4
`endif
`ifndef TL_SOURCE_BITS
`define TL_SOURCE_BITS 4
`endif

module tb_tl_l1_req_arbiter;

    localparam int NREQ = 4;
    localparam int WD   = 8;
    localparam int AW   = `TL_ADDR_BITS;
    localparam int SW   = `TL_SIZE_BITS;
    localparam int DW   = `TL_DATA_BYTES * 8;
    localparam int MW   = `TL_DATA_BYTES;
    localparam int SRCW = `TL_SOURCE_BITS;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [2*NREQ-1:0]    req_type;
    logic [NREQ*AW-1:0]   req_address;
    logic [NREQ*SW-1:0]   req_size;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ*MW-1:0]   req_wmask;
    logic [NREQ-1:0]      resp_valid;
    logic                 resp_err;
    logic [DW-1:0]        resp_rdata;
    logic                 wd_timeout;
    logic                 ad_start;
    logic [1:0]           ad_type;
    logic [AW-1:0]        ad_address;
    logic [SW-1:0]        ad_size;
    logic [SRCW-1:0]      ad_source;
    logic [DW-1:0]        ad_wdata;
    logic [MW-1:0]        ad_wmask;
    logic                 ad_done;
    logic [DW-1:0]        ad_rdata;

    // Per-requester stimulus, packed into the flat buses below.
    logic [1:0]    typ   [NREQ];
    logic [AW-1:0] addr  [NREQ];
    logic [SW-1:0] size  [NREQ];
    logic [DW-1:0] wdata [NREQ];
    logic [MW-1:0] wmask [NREQ];

    int  checks;
    int  errors;
    bit  wd_exp;

    tl_l1_req_arbiter #(
        .NUM_REQ   (NREQ),
        .WD_CYCLES (WD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_type    (req_type),
        .req_address (req_address),
        .req_size    (req_size),
        .req_wdata   (req_wdata),
        .req_wmask   (req_wmask),
        .resp_valid  (resp_valid),
        .resp_err    (resp_err),
        .resp_rdata  (resp_rdata),
        .wd_timeout  (wd_timeout),
        .ad_start    (ad_start),
        .ad_type     (ad_type),
        .ad_address  (ad_address),
        .ad_size     (ad_size),
        .ad_source   (ad_source),
        .ad_wdata    (ad_wdata),
        .ad_wmask    (ad_wmask),
        .ad_done     (ad_done),
        .ad_rdata    (ad_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_type    = '0;
        req_address = '0;
        req_size    = '0;
        req_wdata   = '0;
        req_wmask   = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_type[i*2 +: 2]     = typ[i];
            req_address[i*AW +: AW] = addr[i];
            req_size[i*SW +: SW]   = size[i];
            req_wdata[i*DW +: DW]  = wdata[i];
            req_wmask[i*MW +: MW]  = wmask[i];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Assert reset asynchronously, check every output, release on the next falling edge.
    task automatic do_reset();
        req_valid = '0;
        ad_done   = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_wd_timeout", wd_timeout, 0);
        check("rst_ad_start", ad_start, 0);
        check("rst_ad_type", ad_type, 0);
        check("rst_ad_address", ad_address, 0);
        check("rst_ad_size", ad_size, 0);
        check("rst_ad_source", ad_source, 0);
        check("rst_ad_wdata", ad_wdata, 0);
        check("rst_ad_wmask", ad_wmask, 0);
        wd_exp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a falling edge in an IDLE cycle with req_valid already driven.
    // Follows one transaction owned by 'own'; ad_done is raised in WAIT cycle nwait.
    // Returns at the falling edge of the IDLE cycle that follows RESP.
    task automatic serve(input int own, input int nwait, input logic [DW-1:0] rd,
                         input bit drop);
        logic [NREQ-1:0] oh;
        oh      = '0;
        oh[own] = 1'b1;
        #1;
        check("req_ready", req_ready, oh);
        @(negedge clk);                                 // GRANT
        if (drop) req_valid = req_valid & ~oh;
        check("start_in_grant", ad_start, 0);
        if (typ[own] == 2'd3) begin
            @(negedge clk);                             // RESP
            check("err_resp_valid", resp_valid, oh);
            check("err_flag", resp_err, 1);
            check("err_no_start", ad_start, 0);
        end else begin
            @(negedge clk);                             // ISSUE
            check("ad_start", ad_start, 1);
            check("ad_source", ad_source, own);
            check("ad_type", ad_type, typ[own]);
            check("ad_address", ad_address, addr[own]);
            check("ad_size", ad_size, size[own]);
            check("ad_wdata", ad_wdata, wdata[own]);
            check("ad_wmask", ad_wmask, wmask[own]);
            for (int k = 1; k <= nwait; k++) begin
                @(negedge clk);                         // WAIT cycle k
                check("start_one_cycle", ad_start, 0);
                check("wd_timeout", wd_timeout, (wd_exp || k > WD) ? 1 : 0);
                check("no_early_resp", resp_valid, 0);
                if (k == nwait) begin
                    ad_done  = 1'b1;
                    ad_rdata = rd;
                end
            end
            if (nwait > WD) wd_exp = 1'b1;
            @(negedge clk);                             // RESP
            ad_done  = 1'b0;
            ad_rdata = 32'h0BAD_F00D;
            check("resp_valid", resp_valid, oh);
            check("resp_err", resp_err, 0);
            check("resp_rdata", resp_rdata, (typ[own] == 2'd0) ? rd : '0);
            check("wd_after_done", wd_timeout, wd_exp);
        end
        @(negedge clk);                                 // IDLE
        check("resp_one_cycle", resp_valid, 0);
        check("resp_err_clear", resp_err, 0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        wd_exp    = 1'b0;
        rst_n     = 1'b1;
        req_valid = '0;
        ad_done   = 1'b0;
        ad_rdata  = '0;
        for (int i = 0; i < NREQ; i++) begin
            typ[i]   = 2'd0;
            addr[i]  = 32'h1000 + 32'(i) * 32'h10;
            size[i]  = SW'(i);
            wdata[i] = 32'h1111_0000 + 32'(i);
            wmask[i] = MW'(4'hF);
        end
        #2;
        do_reset();

        // Single GET from requester 0; requester drops valid after acceptance.
        addr[0]   = 32'h100;
        req_valid = 4'b0001;
        serve(0, 3, 32'hDEAD_BEEF, 1'b1);
        check("rdata_hold", resp_rdata, 32'hDEAD_BEEF);

        // ad_done outside WAIT must not produce a response.
        ad_done = 1'b1;
        @(negedge clk);
        ad_done = 1'b0;
        check("stray_done_valid", resp_valid, 0);
        @(negedge clk);
        check("stray_done_valid2", resp_valid, 0);
        check("stray_done_rdata", resp_rdata, 32'hDEAD_BEEF);

        // Round-robin with all four held: 0,1,2,3,0.
        do_reset();
        req_valid = 4'b1111;
        serve(0, 1, 32'hA000_0000, 1'b0);
        serve(1, 2, 32'hA000_0001, 1'b0);
        serve(2, 1, 32'hA000_0002, 1'b0);
        serve(3, 4, 32'hA000_0003, 1'b0);
        serve(0, 1, 32'hA000_0004, 1'b0);
        req_valid = '0;

        // Illegal type from requester 2 (rr_ptr=1 -> 2 is first pending).
        typ[2]    = 2'd3;
        req_valid = 4'b0100;
        serve(2, 0, '0, 1'b1);
        typ[2]    = 2'd0;

        // rr_ptr is now 3: with 0 and 3 pending, 3 wins first, then 0.
        req_valid = 4'b1001;
        serve(3, 2, 32'h3333_3333, 1'b0);
        serve(0, 2, 32'h0000_CAFE, 1'b0);
        req_valid = '0;

        // PUTPARTIAL from requester 1: read data must come back as zero.
        typ[1]    = 2'd2;
        wmask[1]  = MW'(4'h3);
        wdata[1]  = 32'h0000_A5A5;
        req_valid = 4'b0010;
        serve(1, 2, 32'h1234_5678, 1'b1);

        // Watchdog: done withheld for 12 WAIT cycles, timeout appears after 8.
        req_valid = 4'b0001;
        serve(0, 12, 32'h7777_0000, 1'b1);
        check("wd_sticky_idle", wd_timeout, 1);

        // Reset in the middle of WAIT returns everything to reset values.
        req_valid = 4'b0010;
        #1;
        check("pre_rst_ready", req_ready, 4'b0010);
        @(negedge clk);                                 // GRANT
        req_valid = '0;
        @(negedge clk);                                 // ISSUE
        check("pre_rst_start", ad_start, 1);
        @(negedge clk);                                 // WAIT
        check("pre_rst_wd", wd_timeout, 1);
        do_reset();
        // rr_ptr back at 0: requester 0 wins over 1..3.
        req_valid = 4'b1111;
        #1;
        check("post_rst_rr", req_ready, 4'b0001);
        req_valid = '0;
        @(negedge clk);
        check("post_rst_idle", ad_start, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

endmodule
